// File: rtl/bch_stream_ctrl.sv
// Streaming front-end for the BCH(15,7) decoder: issues accepted codewords to the
// decoder, tracks them through its fixed latency with a token pipe, and buffers the
// corrected results in a credit-protected output FIFO with saturating statistics.
module bch_stream_ctrl #(
    parameter int unsigned LAT        = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [14:0]      in_codeword,
    output logic [14:0]      dec_codeword,
    input  logic [14:0]      dec_corrected,
    input  logic             dec_error_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_codeword,
    output logic             out_error_flag,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] stat_words,
    output logic [CNT_W-1:0] stat_corrected,
    output logic             busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold fifo_count + inflight without overflow.
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + LAT + 2) + 1;

    logic             rdy_en_q;
    logic [LAT:0]     tok_q, tok_d;
    logic [CntW-1:0]  inflight;
    logic [CntW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [14:0]      dec_cw_q;
    logic [CNT_W-1:0] words_q, words_d;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic             accept;
    logic             capture;
    logic             pop;

    // Handshake, credit and status decode from registered state only.
    always_comb begin
        inflight  = CntW'($countones(tok_q));
        in_ready  = rdy_en_q & ((fifo_cnt_q + inflight) < CntW'(FIFO_DEPTH));
        accept    = in_valid & in_ready;
        capture   = tok_q[LAT];
        out_valid = (fifo_cnt_q != '0);
        pop       = out_valid & out_ready;
        busy      = (|tok_q) | (fifo_cnt_q != '0);
    end

    // Token pipe mirrors decoder latency; the last stage marks a valid result.
    always_comb begin
        tok_d    = tok_q << 1;
        tok_d[0] = accept;
    end

    // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (capture && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CntW'(1);
        end else if (!capture && pop) begin
            fifo_cnt_d = fifo_cnt_q - CntW'(1);
        end
    end

    // Saturating statistics; a clear wins over a same-cycle capture.
    always_comb begin
        words_d = words_q;
        corr_d  = corr_q;
        if (stat_clear) begin
            words_d = '0;
            corr_d  = '0;
        end else if (capture) begin
            if (words_q != '1) begin
                words_d = words_q + CNT_W'(1);
            end
            if (dec_error_flag && (corr_q != '1)) begin
                corr_d = corr_q + CNT_W'(1);
            end
        end
    end

    // Control state: ready enable, token pipe, decoder input register, counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q   <= 1'b0;
            tok_q      <= '0;
            dec_cw_q   <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            words_q    <= '0;
            corr_q     <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            tok_q      <= tok_d;
            fifo_cnt_q <= fifo_cnt_d;
            words_q    <= words_d;
            corr_q     <= corr_d;
            if (accept) begin
                dec_cw_q <= in_codeword;
            end
            if (capture) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (capture) begin
            mem_q[wr_ptr_q] <= {dec_corrected, dec_error_flag};
        end
    end

    assign dec_codeword   = dec_cw_q;
    assign out_codeword   = mem_q[rd_ptr_q][15:1];
    assign out_error_flag = mem_q[rd_ptr_q][0];
    assign stat_words     = words_q;
    assign stat_corrected = corr_q;

endmodule

// File: tb/tb_bch_stream_ctrl.sv
// Bench for bch_stream_ctrl: two instances (LAT=1/depth 8/16-bit stats and
// LAT=2/depth 4/4-bit stats) driven by a min-distance BCH(15,7) decoder model,
// with per-instance scoreboards of expected {codeword, flag} results.
module tb_bch_stream_ctrl;

    localparam int unsigned LatA = 1;
    localparam int unsigned DepA = 8;
    localparam int unsigned CwA  = 16;
    localparam int unsigned LatB = 2;
    localparam int unsigned DepB = 4;
    localparam int unsigned CwB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid_a = 1'b0, in_ready_a;
    logic [14:0]    in_cw_a = '0, dec_cw_a, dec_corr_a, out_cw_a;
    logic           dec_flag_a, out_valid_a, out_flag_a, busy_a;
    logic           out_ready_a = 1'b0, clr_a = 1'b0;
    logic [CwA-1:0] sw_a, sc_a;

    logic           in_valid_b = 1'b0, in_ready_b;
    logic [14:0]    in_cw_b = '0, dec_cw_b, dec_corr_b, out_cw_b;
    logic           dec_flag_b, out_valid_b, out_flag_b, busy_b;
    logic           out_ready_b = 1'b0, clr_b = 1'b0;
    logic [CwB-1:0] sw_b, sc_b;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int n_checks = 0;
    int n_errors = 0;

    // Systematic encoder, g(x) = x^8 + x^7 + x^6 + x^4 + 1.
    function automatic logic [14:0] bch_encode(input logic [6:0] m);
        logic [14:0] v;
        v = {m, 8'h00};
        for (int i = 14; i >= 8; i--) begin
            if (v[i]) v = v ^ (15'h01D1 << (i - 8));
        end
        return {m, v[7:0]};
    endfunction

    // Nearest-codeword decoder; flag set when any bit was corrected.
    function automatic logic [15:0] bch_decode(input logic [14:0] r);
        logic [14:0] best, c;
        int bd, d;
        best = r;
        bd   = 16;
        for (int m = 0; m < 128; m++) begin
            c = bch_encode(7'(m));
            d = $countones(c ^ r);
            if (d < bd) begin
                bd   = d;
                best = c;
            end
        end
        return {best, (bd != 0)};
    endfunction

    // Decoder stubs with LatA / LatB cycles of latency.
    logic [14:0] pa1, pb1, pb2;
    always @(posedge clk) begin
        pa1 <= dec_cw_a;
        pb1 <= dec_cw_b;
        pb2 <= pb1;
    end
    assign {dec_corr_a, dec_flag_a} = bch_decode(pa1);
    assign {dec_corr_b, dec_flag_b} = bch_decode(pb2);

    bch_stream_ctrl #(.LAT(LatA), .FIFO_DEPTH(DepA), .CNT_W(CwA)) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid_a),
        .in_ready       (in_ready_a),
        .in_codeword    (in_cw_a),
        .dec_codeword   (dec_cw_a),
        .dec_corrected  (dec_corr_a),
        .dec_error_flag (dec_flag_a),
        .out_valid      (out_valid_a),
        .out_ready      (out_ready_a),
        .out_codeword   (out_cw_a),
        .out_error_flag (out_flag_a),
        .stat_clear     (clr_a),
        .stat_words     (sw_a),
        .stat_corrected (sc_a),
        .busy           (busy_a)
    );

    bch_stream_ctrl #(.LAT(LatB), .FIFO_DEPTH(DepB), .CNT_W(CwB)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid_b),
        .in_ready       (in_ready_b),
        .in_codeword    (in_cw_b),
        .dec_codeword   (dec_cw_b),
        .dec_corrected  (dec_corr_b),
        .dec_error_flag (dec_flag_b),
        .out_valid      (out_valid_b),
        .out_ready      (out_ready_b),
        .out_codeword   (out_cw_b),
        .out_error_flag (out_flag_b),
        .stat_clear     (clr_b),
        .stat_words     (sw_b),
        .stat_corrected (sc_b),
        .busy           (busy_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake; reset discards all entries.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (out_valid_a && out_ready_a) begin
                if (q_a.size() == 0) check("a_extra_word", 64'(q_a.size()), 64'(1));
                else check("a_word", 64'({out_cw_a, out_flag_a}), 64'(q_a.pop_front()));
            end
            if (out_valid_b && out_ready_b) begin
                if (q_b.size() == 0) check("b_extra_word", 64'(q_b.size()), 64'(1));
                else check("b_word", 64'({out_cw_b, out_flag_b}), 64'(q_b.pop_front()));
            end
        end
    end

    // Offer one word until accepted; the expected result is queued on acceptance.
    task automatic send(input bit sel, input logic [14:0] cw, input logic [15:0] exp);
        bit ok = 1'b0;
        int guard = 0;
        while (!ok && guard < 200) begin
            if (sel) begin
                in_valid_b = 1'b1;
                in_cw_b    = cw;
                ok         = in_ready_b;
                if (ok) q_b.push_back(exp);
            end else begin
                in_valid_a = 1'b1;
                in_cw_a    = cw;
                ok         = in_ready_a;
                if (ok) q_a.push_back(exp);
            end
            @(negedge clk);
            guard++;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check("send_accept", 64'(ok), 64'(1));
    endtask

    task automatic drain(input bit sel);
        int n = 0;
        while ((sel ? busy_b : busy_a) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "b_drain" : "a_drain", 64'(sel ? busy_b : busy_a), 64'(0));
    endtask

    // Random codeword with a 1- or 2-bit error pattern.
    function automatic logic [14:0] corrupt(input logic [14:0] cw);
        int p1, p2;
        logic [14:0] err;
        p1  = int'($urandom_range(0, 14));
        err = 15'(1) << p1;
        if ($urandom_range(0, 1) == 1) begin
            p2  = (p1 + 1 + int'($urandom_range(0, 13))) % 15;
            err = err | (15'(1) << p2);
        end
        return cw ^ err;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] cw;
        int lat, acc_n;
        time t0;

        // Reset held for three cycles: everything at its reset value.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ctl_a", 64'({in_ready_a, out_valid_a, out_flag_a, busy_a}), 64'(0));
            check("rst_data_a", 64'({out_cw_a, dec_cw_a, sw_a, sc_a}), 64'(0));
            check("rst_b", 64'({in_ready_b, out_valid_b, out_cw_b, out_flag_b, dec_cw_b,
                                sw_b, sc_b, busy_b}), 64'(0));
        end
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready_a", 64'(in_ready_a), 64'(1));
        check("rel_busy_a", 64'(busy_a), 64'(0));
        check("rel_ready_b", 64'(in_ready_b), 64'(1));
        check("rel_busy_b", 64'(busy_b), 64'(0));

        // Single word: out_valid appears LAT+2 cycles after the accept cycle.
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        in_cw_a     = 15'h1A2B;
        check("single_ready", 64'(in_ready_a), 64'(1));
        q_a.push_back(bch_decode(15'h1A2B));
        @(negedge clk);
        in_valid_a = 1'b0;
        lat = 1;
        while (!out_valid_a && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("single_latency", 64'(lat), 64'(LatA + 2));
        check("single_stat_words", 64'(sw_a), 64'(1));
        drain(0);

        // Streaming 120 corrupted words at full rate.
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("a_clear", 64'({sw_a, sc_a}), 64'(0));
        t0 = $time;
        for (int i = 0; i < 120; i++) begin
            cw = bch_encode(7'($urandom_range(0, 127)));
            send(0, corrupt(cw), {cw, 1'b1});
        end
        check("a_stream_rate", 64'(($time - t0) / 10), 64'(120));
        drain(0);
        check("a_stat_words", 64'(sw_a), 64'(120));
        check("a_stat_corr", 64'(sc_a), 64'(120));

        // Back-pressure on B: exactly DepB accepts, then stall, then in-order drain.
        out_ready_b = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid_b = 1'b1;
            in_cw_b    = bch_encode(7'(acc_n + 1));
            if (in_ready_b) begin
                q_b.push_back({in_cw_b, 1'b0});
                acc_n++;
            end
            @(negedge clk);
        end
        in_valid_b = 1'b0;
        check("bp_accepts", 64'(acc_n), 64'(DepB));
        check("bp_ready_low", 64'(in_ready_b), 64'(0));
        check("bp_busy", 64'(busy_b), 64'(1));
        check("bp_head", 64'({out_valid_b, out_cw_b, out_flag_b}), 64'({1'b1, bch_encode(7'd1), 1'b0}));
        out_ready_b = 1'b1;
        check("bp_ready_before_pop", 64'(in_ready_b), 64'(0));
        @(negedge clk);
        check("bp_ready_after_pop", 64'(in_ready_b), 64'(1));
        drain(1);

        // Stats on B (4-bit): saturation, then clear coinciding with a capture.
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cw = bch_encode(7'($urandom_range(0, 127)));
            send(1, corrupt(cw), {cw, 1'b1});
        end
        drain(1);
        check("b_sat_words", 64'(sw_b), 64'(15));
        check("b_sat_corr", 64'(sc_b), 64'(15));
        cw = bch_encode(7'h55);
        in_valid_b = 1'b1;
        in_cw_b    = cw ^ 15'h0001;
        check("clr_ready", 64'(in_ready_b), 64'(1));
        q_b.push_back({cw, 1'b1});
        @(negedge clk);
        in_valid_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        check("clr_captured", 64'(out_valid_b), 64'(1));
        check("clr_stats", 64'({sw_b, sc_b}), 64'(0));
        drain(1);
        send(1, cw ^ 15'h0100, {cw, 1'b1});
        drain(1);
        check("clr_resume", 64'({sw_b, sc_b}), 64'({4'd1, 4'd1}));

        // Mid-stream reset on A: 3 buffered, 2 in flight, then reset.
        out_ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cw = bch_encode(7'(i + 10));
            send(0, cw, {cw, 1'b0});
        end
        check("mid_pre_busy", 64'({busy_a, out_valid_a}), 64'(3));
        check("mid_pre_words", 64'(sw_a), 64'(123));
        rst = 1'b0;
        #1;
        check("mid_rst_out", 64'({out_valid_a, busy_a, in_ready_a}), 64'(0));
        check("mid_rst_stats", 64'({sw_a, sc_a}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        out_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_no_stale", 64'(out_valid_a), 64'(0));
        end
        for (int i = 0; i < 3; i++) begin
            cw = bch_encode(7'(i + 100));
            send(0, corrupt(cw), {cw, 1'b1});
        end
        drain(0);
        check("mid_post_words", 64'(sw_a), 64'(3));

        check("a_sb_empty", 64'(q_a.size()), 64'(0));
        check("b_sb_empty", 64'(q_b.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
